// File: rtl/regfile_wr_arbiter.sv
// Register file write-port arbiter.
// The writeback stage and the multi-cycle MDU share one register file write port.
// MDU results wait in a small circular FIFO and drain into cycles the pipeline leaves idle.
// Two checks can override that: a starvation limit, and a same-destination ordering rule.
//
// Handshakes: an MDU result transfers on a cycle where mdu_valid_i && mdu_ready_o.
// The MDU must not depend on mdu_ready_o to raise mdu_valid_i.
// A pipeline request (pipe_we_i with pipe_rd_i != 0) is accepted on a cycle where pipe_stall_o is low.
// The writeback stage re-presents a stalled request unchanged.
module regfile_wr_arbiter #(
   parameter int XLEN         = 32,
   parameter int RA_W         = 5,
   parameter int BUF_DEPTH    = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic            clk_i,
   input  logic            reset_i,
   input  logic            pipe_we_i,
   input  logic [RA_W-1:0] pipe_rd_i,
   input  logic [XLEN-1:0] pipe_data_i,
   output logic            pipe_stall_o,
   input  logic            mdu_valid_i,
   input  logic [RA_W-1:0] mdu_rd_i,
   input  logic [XLEN-1:0] mdu_data_i,
   output logic            mdu_ready_o,
   output logic            rf_we_o,
   output logic [RA_W-1:0] rf_rd_o,
   output logic [XLEN-1:0] rf_data_o
);

   localparam int IDX_W = $clog2(BUF_DEPTH);
   localparam int PTR_W = IDX_W + 1;
   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

   typedef enum logic [1:0] {
      GNT_IDLE = 2'd0,
      GNT_PIPE = 2'd1,
      GNT_FIFO = 2'd2
   } grant_e;

   // FIFO storage; the valid bits mirror occupancy so every live entry can be matched by rd
   logic [RA_W-1:0]      buf_rd_q   [BUF_DEPTH];
   logic [XLEN-1:0]      buf_data_q [BUF_DEPTH];
   logic [BUF_DEPTH-1:0] buf_vld_q, buf_vld_d;

   // Pointers carry one extra wrap bit so full and empty are distinct
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [IDX_W-1:0] wr_idx, rd_idx;

   logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

   logic            rf_we_q, rf_we_d;
   logic [RA_W-1:0] rf_rd_q, rf_rd_d;
   logic [XLEN-1:0] rf_data_q, rf_data_d;

   logic   fifo_empty, fifo_full;
   logic   pipe_req, order_hit, force_fifo;
   logic   push, pop;
   grant_e grant;

   assign wr_idx     = wr_ptr_q[IDX_W-1:0];
   assign rd_idx     = rd_ptr_q[IDX_W-1:0];
   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]) &&
                       (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]);

   // Writes to x0 are discarded architecturally, so they never compete for the port
   assign pipe_req   = pipe_we_i && (pipe_rd_i != '0);
   assign force_fifo = !fifo_empty && (starve_cnt_q == STARVE_MAX);

   // Pipeline destination matching any buffered MDU destination (older write must land first)
   always_comb begin
      order_hit = 1'b0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
         if (buf_vld_q[i] && (buf_rd_q[i] == pipe_rd_i)) begin
            order_hit = 1'b1;
         end
      end
   end

   // Grant priority: forced drain, ordering drain, pipeline, idle-slot drain
   always_comb begin
      grant = GNT_IDLE;
      if (!reset_i) begin
         if (force_fifo) begin
            grant = GNT_FIFO;
         end else if (pipe_req && order_hit) begin
            grant = GNT_FIFO;
         end else if (pipe_req) begin
            grant = GNT_PIPE;
         end else if (!fifo_empty) begin
            grant = GNT_FIFO;
         end
      end
   end

   // Readiness looks at current occupancy only; a same-cycle pop does not open a slot
   assign mdu_ready_o  = !fifo_full && !reset_i;
   // A FIFO grant while the pipeline is requesting can only come from the force or ordering rule
   assign pipe_stall_o = pipe_req && (grant == GNT_FIFO);

   assign pop  = (grant == GNT_FIFO);
   assign push = mdu_valid_i && mdu_ready_o && (mdu_rd_i != '0);

   // Next-state for pointers, valid bits, starvation counter and the write-port register
   always_comb begin
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      buf_vld_d    = buf_vld_q;
      starve_cnt_d = starve_cnt_q;
      rf_we_d      = 1'b0;
      rf_rd_d      = '0;
      rf_data_d    = '0;

      if (pop) begin
         buf_vld_d[rd_idx] = 1'b0;
         rd_ptr_d          = rd_ptr_q + PTR_W'(1);
      end
      if (push) begin
         buf_vld_d[wr_idx] = 1'b1;
         wr_ptr_d          = wr_ptr_q + PTR_W'(1);
      end

      if (fifo_empty || pop) begin
         starve_cnt_d = '0;
      end else if (starve_cnt_q != STARVE_MAX) begin
         starve_cnt_d = starve_cnt_q + CNT_W'(1);
      end

      case (grant)
         GNT_PIPE: begin
            rf_we_d   = 1'b1;
            rf_rd_d   = pipe_rd_i;
            rf_data_d = pipe_data_i;
         end
         GNT_FIFO: begin
            rf_we_d   = 1'b1;
            rf_rd_d   = buf_rd_q[rd_idx];
            rf_data_d = buf_data_q[rd_idx];
         end
         default: begin
            rf_we_d   = 1'b0;
         end
      endcase
   end

   // Control state and registered write port; reset empties the FIFO and drops any pending write
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         buf_vld_q    <= '0;
         starve_cnt_q <= '0;
         rf_we_q      <= 1'b0;
         rf_rd_q      <= '0;
         rf_data_q    <= '0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         buf_vld_q    <= buf_vld_d;
         starve_cnt_q <= starve_cnt_d;
         rf_we_q      <= rf_we_d;
         rf_rd_q      <= rf_rd_d;
         rf_data_q    <= rf_data_d;
      end
   end

   // Entry payload storage; contents are only meaningful where the matching valid bit is set
   always_ff @(posedge clk_i) begin
      if (push) begin
         buf_rd_q[wr_idx]   <= mdu_rd_i;
         buf_data_q[wr_idx] <= mdu_data_i;
      end
   end

   assign rf_we_o   = rf_we_q;
   assign rf_rd_o   = rf_rd_q;
   assign rf_data_o = rf_data_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Testbench for regfile_wr_arbiter: directed vectors, a queue-based reference model
// checked every cycle, and hand-computed expectations for the key scenarios.
module tb_regfile_wr_arbiter;

   localparam int XLEN         = 32;
   localparam int RA_W         = 5;
   localparam int BUF_DEPTH    = 2;
   localparam int STARVE_LIMIT = 4;

   // ---------------- clock / reset ----------------
   logic            clk = 1'b0;
   logic            reset_i = 1'b1;
   logic            pipe_we_i = 1'b0;
   logic [RA_W-1:0] pipe_rd_i = '0;
   logic [XLEN-1:0] pipe_data_i = '0;
   logic            mdu_valid_i = 1'b0;
   logic [RA_W-1:0] mdu_rd_i = '0;
   logic [XLEN-1:0] mdu_data_i = '0;
   logic            pipe_stall_o, mdu_ready_o, rf_we_o;
   logic [RA_W-1:0] rf_rd_o;
   logic [XLEN-1:0] rf_data_o;

   always #5 clk = ~clk;

   regfile_wr_arbiter #(
      .XLEN(XLEN), .RA_W(RA_W), .BUF_DEPTH(BUF_DEPTH), .STARVE_LIMIT(STARVE_LIMIT)
   ) dut (
      .clk_i       (clk),
      .reset_i     (reset_i),
      .pipe_we_i   (pipe_we_i),
      .pipe_rd_i   (pipe_rd_i),
      .pipe_data_i (pipe_data_i),
      .pipe_stall_o(pipe_stall_o),
      .mdu_valid_i (mdu_valid_i),
      .mdu_rd_i    (mdu_rd_i),
      .mdu_data_i  (mdu_data_i),
      .mdu_ready_o (mdu_ready_o),
      .rf_we_o     (rf_we_o),
      .rf_rd_o     (rf_rd_o),
      .rf_data_o   (rf_data_o)
   );

   int n_checks = 0;
   int n_fail   = 0;
   bit model_on = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
      end
   endtask

   // ---------------- driver tasks ----------------
   // Inputs change on the falling edge; the DUT samples them on the next rising edge.
   task automatic drive(input logic rst, input logic pwe, input logic [RA_W-1:0] prd,
                        input logic [XLEN-1:0] pdata, input logic mv,
                        input logic [RA_W-1:0] mrd, input logic [XLEN-1:0] mdata);
      @(negedge clk);
      reset_i     = rst;
      pipe_we_i   = pwe;
      pipe_rd_i   = prd;
      pipe_data_i = pdata;
      mdu_valid_i = mv;
      mdu_rd_i    = mrd;
      mdu_data_i  = mdata;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
   endtask

   // ---------------- reference model / scoreboard ----------------
   // Buffered MDU results, oldest first, packed as {rd, data}.
   logic [RA_W+XLEN-1:0] exp_q[$];
   int                   starve = 0;
   logic                 exp_we = 1'b0;
   logic [RA_W-1:0]      exp_rd = '0;
   logic [XLEN-1:0]      exp_data = '0;

   always begin
      bit pipe_req, hit, take_fifo, take_pipe, exp_stall, exp_ready, was_nonempty;
      @(negedge clk);
      #2;
      if (model_on) begin
         check("rf_we", 32'(rf_we_o), 32'(exp_we));
         check("rf_rd", 32'(rf_rd_o), 32'(exp_rd));
         check("rf_data", rf_data_o, exp_data);

         pipe_req  = pipe_we_i && (pipe_rd_i != 0);
         hit       = 1'b0;
         take_fifo = 1'b0;
         take_pipe = 1'b0;
         foreach (exp_q[i]) begin
            if (exp_q[i][XLEN +: RA_W] == pipe_rd_i) hit = 1'b1;
         end
         was_nonempty = (exp_q.size() > 0);

         if (reset_i) begin
            exp_stall = 1'b0;
            exp_ready = 1'b0;
         end else begin
            if (was_nonempty && starve == STARVE_LIMIT) take_fifo = 1'b1;
            else if (pipe_req && hit)                   take_fifo = 1'b1;
            else if (pipe_req)                          take_pipe = 1'b1;
            else if (was_nonempty)                      take_fifo = 1'b1;
            exp_stall = pipe_req && take_fifo;
            exp_ready = (exp_q.size() < BUF_DEPTH);
         end
         check("pipe_stall", 32'(pipe_stall_o), 32'(exp_stall));
         check("mdu_ready", 32'(mdu_ready_o), 32'(exp_ready));

         if (reset_i) begin
            exp_q.delete();
            starve   = 0;
            exp_we   = 1'b0;
            exp_rd   = '0;
            exp_data = '0;
         end else begin
            if (!was_nonempty || take_fifo) starve = 0;
            else if (starve < STARVE_LIMIT) starve = starve + 1;

            exp_we   = take_fifo || take_pipe;
            exp_rd   = '0;
            exp_data = '0;
            if (take_pipe) begin
               exp_rd   = pipe_rd_i;
               exp_data = pipe_data_i;
            end else if (take_fifo) begin
               logic [RA_W+XLEN-1:0] head;
               head     = exp_q.pop_front();
               exp_rd   = head[XLEN +: RA_W];
               exp_data = head[XLEN-1:0];
            end
            if (mdu_valid_i && exp_ready && mdu_rd_i != 0) begin
               exp_q.push_back({mdu_rd_i, mdu_data_i});
            end
         end
      end
   end

   // ---------------- directed stimulus with literal expectations ----------------
   initial begin
      @(posedge clk);
      model_on = 1'b1;
      // Reset held; a pipeline request during reset must not stall
      drive(1'b1, 1'b1, 5'd5, 32'h1, 1'b0, '0, '0);
      #3; check("rst_stall", 32'(pipe_stall_o), 32'd0);
      check("rst_ready", 32'(mdu_ready_o), 32'd0);
      check("rst_rf_we", 32'(rf_we_o), 32'd0);

      // 1. pipeline only
      drive(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0);
      #3; check("t1_stall", 32'(pipe_stall_o), 32'd0);
      idle();
      #3; check("t1_we", 32'(rf_we_o), 32'd1);
      check("t1_rd", 32'(rf_rd_o), 32'd5);
      check("t1_data", rf_data_o, 32'hDEADBEEF);

      // 2a. MDU result drained into an idle slot two cycles after the handshake
      drive(1'b0, 1'b0, '0, '0, 1'b1, 5'd7, 32'h12);
      #3; check("t2_ready", 32'(mdu_ready_o), 32'd1);
      idle();
      #3; check("t2_we_early", 32'(rf_we_o), 32'd0);
      idle();
      #3; check("t2_we", 32'(rf_we_o), 32'd1);
      check("t2_rd", 32'(rf_rd_o), 32'd7);
      check("t2_data", rf_data_o, 32'h12);

      // 2b. fill both entries behind a busy pipeline, then drain in order
      drive(1'b0, 1'b1, 5'd10, 32'hA, 1'b1, 5'd11, 32'hB);
      drive(1'b0, 1'b1, 5'd12, 32'hC, 1'b1, 5'd13, 32'hD);
      #3; check("t2b_ready1", 32'(mdu_ready_o), 32'd1);
      drive(1'b0, 1'b1, 5'd14, 32'hE, 1'b1, 5'd27, 32'hF);
      #3; check("t2b_full", 32'(mdu_ready_o), 32'd0);
      check("t2b_stall", 32'(pipe_stall_o), 32'd0);
      idle();
      #3; check("t2b_rd14", 32'(rf_rd_o), 32'd14);
      idle();
      #3; check("t2b_rd11", 32'(rf_rd_o), 32'd11);
      idle();
      #3; check("t2b_rd13", 32'(rf_rd_o), 32'd13);
      check("t2b_data13", rf_data_o, 32'hD);

      // 3. starvation: four pipeline wins, then a forced drain
      drive(1'b0, 1'b1, 5'd3, 32'h300, 1'b1, 5'd20, 32'h2000);
      for (int i = 0; i < STARVE_LIMIT; i++) begin
         drive(1'b0, 1'b1, 5'd3, 32'h301 + 32'(i), 1'b0, '0, '0);
         #3; check("t3_nostall", 32'(pipe_stall_o), 32'd0);
      end
      drive(1'b0, 1'b1, 5'd3, 32'h3FF, 1'b0, '0, '0);
      #3; check("t3_force_stall", 32'(pipe_stall_o), 32'd1);
      drive(1'b0, 1'b1, 5'd3, 32'h3FF, 1'b0, '0, '0);
      #3; check("t3_after_stall", 32'(pipe_stall_o), 32'd0);
      check("t3_forced_rd", 32'(rf_rd_o), 32'd20);
      check("t3_forced_data", rf_data_o, 32'h2000);
      idle();
      #3; check("t3_pipe_rd", 32'(rf_rd_o), 32'd3);
      check("t3_pipe_data", rf_data_o, 32'h3FF);

      // 4. ordering: buffered x9 must land before the pipeline's x9
      drive(1'b0, 1'b0, '0, '0, 1'b1, 5'd9, 32'h900);
      drive(1'b0, 1'b1, 5'd9, 32'h999, 1'b0, '0, '0);
      #3; check("t4_stall", 32'(pipe_stall_o), 32'd1);
      drive(1'b0, 1'b1, 5'd9, 32'h999, 1'b0, '0, '0);
      #3; check("t4_nostall", 32'(pipe_stall_o), 32'd0);
      check("t4_first_data", rf_data_o, 32'h900);
      idle();
      #3; check("t4_second_rd", 32'(rf_rd_o), 32'd9);
      check("t4_second_data", rf_data_o, 32'h999);

      // 5a. MDU result to x0: handshaken, never written
      drive(1'b0, 1'b0, '0, '0, 1'b1, 5'd0, 32'h55);
      #3; check("t5_x0_ready", 32'(mdu_ready_o), 32'd1);
      idle();
      idle();
      #3; check("t5_x0_nowrite", 32'(rf_we_o), 32'd0);
      // 5b. pipeline request to x0: no stall, no write
      drive(1'b0, 1'b1, 5'd0, 32'h77, 1'b0, '0, '0);
      #3; check("t5_p0_stall", 32'(pipe_stall_o), 32'd0);
      idle();
      #3; check("t5_p0_nowrite", 32'(rf_we_o), 32'd0);
      // 5c. push and pop in the same cycle at occupancy 1
      drive(1'b0, 1'b1, 5'd15, 32'h15, 1'b1, 5'd21, 32'hA1);
      drive(1'b0, 1'b0, '0, '0, 1'b1, 5'd22, 32'hA2);
      #3; check("t5_pp_ready", 32'(mdu_ready_o), 32'd1);
      idle();
      #3; check("t5_pp_rd21", 32'(rf_rd_o), 32'd21);
      idle();
      #3; check("t5_pp_rd22", 32'(rf_rd_o), 32'd22);
      check("t5_pp_data22", rf_data_o, 32'hA2);
      idle();
      #3; check("t5_pp_empty", 32'(rf_we_o), 32'd0);

      // 6. reset with two buffered entries and the starvation count at 3
      drive(1'b0, 1'b1, 5'd1, 32'h11, 1'b1, 5'd24, 32'h24);
      drive(1'b0, 1'b1, 5'd2, 32'h22, 1'b1, 5'd25, 32'h25);
      drive(1'b0, 1'b1, 5'd4, 32'h44, 1'b0, '0, '0);
      #3; check("t6_full", 32'(mdu_ready_o), 32'd0);
      drive(1'b0, 1'b1, 5'd6, 32'h66, 1'b0, '0, '0);
      #3; check("t6_pre_stall", 32'(pipe_stall_o), 32'd0);
      drive(1'b1, 1'b1, 5'd8, 32'h88, 1'b1, 5'd26, 32'h26);
      #3; check("t6_rst_stall", 32'(pipe_stall_o), 32'd0);
      check("t6_rst_ready", 32'(mdu_ready_o), 32'd0);
      idle();
      #3; check("t6_post_we", 32'(rf_we_o), 32'd0);
      check("t6_post_rd", 32'(rf_rd_o), 32'd0);
      check("t6_post_data", rf_data_o, 32'd0);
      check("t6_post_ready", 32'(mdu_ready_o), 32'd1);
      for (int i = 0; i < 4; i++) begin
         idle();
         #3; check("t6_no_stale", 32'(rf_we_o), 32'd0);
      end

      idle();
      #3;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/regfile_wr_arbiter.md
# regfile_wr_arbiter

Shares the register file's single write port between the pipeline writeback stage and the multi-cycle multiply/divide unit (MDU). MDU results are captured into a small FIFO and drained whenever the writeback stage leaves the port idle. A starvation counter bounds how long a buffered result can wait. A same-destination check keeps writes to each register in program order. The block sits between the writeback-stage result mux and the register file write port, and drives the writeback stall back into the pipeline.

## Interface
Parameters:
- XLEN, 32, data width
- RA_W, 5, register address width
- BUF_DEPTH, 2, MDU result FIFO entries (power of two, ≥2)
- STARVE_LIMIT, 4, consecutive lost arbitrations before a FIFO entry is forced through

Ports:
- clk_i  in  1  clock; all state updates on the rising edge
- reset_i  in  1  synchronous, active-high reset
- pipe_we_i  in  1  writeback stage requests a register write this cycle
- pipe_rd_i  in  RA_W  writeback destination register
- pipe_data_i  in  XLEN  writeback data
- pipe_stall_o  out  1  pipeline write not accepted this cycle; writeback holds its inputs
- mdu_valid_i  in  1  MDU result valid
- mdu_rd_i  in  RA_W  MDU destination register
- mdu_data_i  in  XLEN  MDU result
- mdu_ready_o  out  1  FIFO can accept an MDU result
- rf_we_o  out  1  register file write enable (registered)
- rf_rd_o  out  RA_W  register file write address (registered)
- rf_data_o  out  XLEN  register file write data (registered)

## Operation
- **MDU handshake.** A transfer occurs when both mdu_valid_i and mdu_ready_o are high.
  - mdu_ready_o = !full && !reset_i.
  - Readiness is computed from the current occupancy only. A pop in the same cycle does not free a slot early.
- **x0 writes.**
  - A pipeline request with rd = 0 is treated as no request and is never stalled.
  - An MDU transfer with rd = 0 completes the handshake but is not pushed.
- **Grant priority** (one grant per cycle, in this order):
  1. Force FIFO: FIFO is non-empty and starve_cnt == STARVE_LIMIT.
  2. Order FIFO: pipe_we_i is high and pipe_rd_i matches the rd of any valid FIFO entry. The older MDU write must land first.
  3. Pipe: pipe_we_i is high and neither of the above applies.
  4. FIFO: FIFO is non-empty and there is no pipeline request.
  5. Idle.
- **Stall.** pipe_stall_o = pipe_we_i && (pipe_rd_i != 0) && (grant is rule 1 or rule 2).
- **Starvation counter.**
  - starve_cnt increments when the FIFO is non-empty and the head is not granted.
  - It clears on a FIFO grant, and also clears when the FIFO is empty.
  - It saturates at STARVE_LIMIT.
- **FIFO behaviour.**
  - Ordered circular buffer with wrap-around read and write pointers.
  - Push and pop may occur in the same cycle.
  - Occupancy is tracked with an extra pointer bit or a count, so full and empty are unambiguous.
  - A grant pops the head entry.
- **Reset.**
  - The FIFO is emptied, starve_cnt = 0, and rf_we_o/rf_rd_o/rf_data_o = 0.
  - pipe_stall_o and mdu_ready_o are 0 while reset_i is high.
  - Any write in progress is discarded. An MDU handshake during reset does not complete.

## Timing
- Pipeline request accepted in cycle N → rf_we_o high in N+1 with that rd and data.
- MDU transfer in cycle N → earliest grant N+1 → rf_we_o high in N+2.
- pipe_stall_o is combinational, valid in the same cycle as the request. The writeback stage re-presents the request each stalled cycle.
- Worst-case wait for a FIFO head entry is STARVE_LIMIT cycles of lost arbitration.
- A pipeline stall caused by an ordering conflict lasts until every matching entry has drained. Each drain takes one cycle per entry at or ahead of the match.
- Sustained throughput is one register write per cycle. The port is never idle while a request is pending.

## Test plan
1. **Pipeline only.** pipe_we_i = 1, rd = 5, data = 0xDEADBEEF, FIFO empty → no stall; next cycle rf_we_o = 1, rf_rd_o = 5, rf_data_o = 0xDEADBEEF.
2. **Idle-slot drain and backpressure.**
   - MDU pushes rd = 7, data = 0x12 with the pipeline idle → rf_we_o = 1 with rd = 7 exactly two cycles after the handshake.
   - Fill both entries while the pipeline is continuously busy → mdu_ready_o = 0.
3. **Starvation.** Fill one entry, then hold pipe_we_i = 1 (rd = 3) continuously → the pipeline is granted 4 cycles; on the 5th cycle pipe_stall_o = 1 and the FIFO entry is written; the cycle after that the pipeline is granted with no stall.
4. **Ordering.** FIFO holds rd = 9, then the pipeline requests rd = 9 → pipe_stall_o = 1 for one cycle; the register file sees the MDU write to x9 followed by the pipeline write to x9.
5. **x0 and simultaneous push/pop.**
   - An MDU result to rd = 0 is handshaken and never written.
   - A pipeline request to rd = 0 gets no stall and no write.
   - Push and pop in the same cycle with occupancy 1 → occupancy stays 1 and the entry order is preserved.
6. **Reset mid-operation.** FIFO holds 2 entries and starve_cnt = 3; assert reset_i for 1 cycle → all outputs are 0 during reset; afterwards the FIFO is empty, mdu_ready_o = 1, and no stale write ever reaches the register file.
